// File: rtl/pb_tap_ir_ctrl.sv
// pb_tap_ir_ctrl: IEEE 1149.1 TAP FSM plus instruction register.
// Define PB_TAP_STATE_DBG_EN to expose the FSM state on tapState_o.
module pb_tap_ir_ctrl #(
  parameter int unsigned         IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] IR_RESET   = {IR_WIDTH{1'b1}}
) (
  input  logic                tck_i,
  input  logic                rst_ni,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic [IR_WIDTH-1:0] irInstruction_o,
  output logic                irTdo_o,
  output logic                tdoEnable_o,
  output logic                captureDR_o,
  output logic                shiftDR_o,
  output logic                updateDR_o,
  output logic                shiftIR_o,
  output logic                tapReset_o
`ifdef PB_TAP_STATE_DBG_EN
  ,
  output logic [3:0]          tapState_o
`endif
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PA_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PA_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] shift_q, shift_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;

  // TAP next-state decode from the registered state and tms_i
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = tms_i ? TLR    : RTI;
      RTI:    state_d = tms_i ? SEL_DR : RTI;
      SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms_i ? UPD_DR : PA_DR;
      PA_DR:  state_d = tms_i ? EX2_DR : PA_DR;
      EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms_i ? SEL_DR : RTI;
      SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
      CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms_i ? UPD_IR : PA_IR;
      PA_IR:  state_d = tms_i ? EX2_IR : PA_IR;
      EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms_i ? SEL_DR : RTI;
    endcase
  end

  // IR shift/update actions keyed on the current state
  always_comb begin
    shift_d = shift_q;
    ir_d    = ir_q;
    unique case (state_q)
      CAP_IR:  shift_d = IR_CAPTURE;
      SH_IR:   shift_d = {tdi_i, shift_q[IR_WIDTH-1:1]};
      UPD_IR:  ir_d    = shift_q;
      TLR:     ir_d    = IR_RESET;
      default: ;
    endcase
  end

  // State and IR registers; synchronous reset wins over everything
  always_ff @(posedge tck_i) begin
    if (!rst_ni) begin
      state_q <= TLR;
      shift_q <= IR_CAPTURE;
      ir_q    <= IR_RESET;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      ir_q    <= ir_d;
    end
  end

  assign irInstruction_o = ir_q;
  assign irTdo_o         = shift_q[0];
  assign captureDR_o     = (state_q == CAP_DR);
  assign shiftDR_o       = (state_q == SH_DR);
  assign updateDR_o      = (state_q == UPD_DR);
  assign shiftIR_o       = (state_q == SH_IR);
  assign tapReset_o      = (state_q == TLR);
  assign tdoEnable_o     = shiftDR_o | shiftIR_o;

`ifdef PB_TAP_STATE_DBG_EN
  assign tapState_o = state_q;
`endif

endmodule

// File: tb/tb_pb_tap_ir_ctrl.sv
// tb_pb_tap_ir_ctrl: scoreboard bench for the TAP controller.
// A reference TAP model queues expected outputs per edge.
module tb_pb_tap_ir_ctrl;

  logic       tck_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       tms_i = 1'b0;
  logic       tdi_i = 1'b0;
  logic [3:0] ir;
  logic       tdo, tdoen, cap, shdr, upd, shir, trst;

  pb_tap_ir_ctrl dut (
    .tck_i           (tck_i),
    .rst_ni          (rst_ni),
    .tms_i           (tms_i),
    .tdi_i           (tdi_i),
    .irInstruction_o (ir),
    .irTdo_o         (tdo),
    .tdoEnable_o     (tdoen),
    .captureDR_o     (cap),
    .shiftDR_o       (shdr),
    .updateDR_o      (upd),
    .shiftIR_o       (shir),
    .tapReset_o      (trst)
  );

  always #5 tck_i = ~tck_i;

  typedef struct packed {
    logic [3:0] ir;
    logic       tdo;
    logic [5:0] strb;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         m_st   = 0;
  logic [3:0] m_sh   = 4'b0001;
  logic [3:0] m_ir   = 4'b1111;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int nxt(input int s, input logic t);
    case (s)
      0:       return t ? 0  : 1;
      1:       return t ? 2  : 1;
      2:       return t ? 9  : 3;
      3:       return t ? 5  : 4;
      4:       return t ? 5  : 4;
      5:       return t ? 8  : 6;
      6:       return t ? 7  : 6;
      7:       return t ? 8  : 4;
      8:       return t ? 2  : 1;
      9:       return t ? 0  : 10;
      10:      return t ? 12 : 11;
      11:      return t ? 12 : 11;
      12:      return t ? 15 : 13;
      13:      return t ? 14 : 13;
      14:      return t ? 15 : 11;
      default: return t ? 2  : 1;
    endcase
  endfunction

  task automatic step(input logic rn, input logic tms, input logic tdi);
    exp_t e;
    exp_t o;
    rst_ni = rn;
    tms_i  = tms;
    tdi_i  = tdi;
    @(posedge tck_i);
    if (!rn) begin
      m_st = 0;
      m_sh = 4'b0001;
      m_ir = 4'b1111;
    end else begin
      if (m_st == 10)      m_sh = 4'b0001;
      else if (m_st == 11) m_sh = {tdi, m_sh[3:1]};
      else if (m_st == 15) m_ir = m_sh;
      else if (m_st == 0)  m_ir = 4'b1111;
      m_st = nxt(m_st, tms);
    end
    e.ir   = m_ir;
    e.tdo  = m_sh[0];
    e.strb = {(m_st == 4) || (m_st == 11), m_st == 3, m_st == 4,
              m_st == 8, m_st == 11, m_st == 0};
    exp_q.push_back(e);
    @(negedge tck_i);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      o = exp_q.pop_front();
      check("sb_ir", 32'(ir), 32'(o.ir));
      check("sb_tdo", 32'(tdo), 32'(o.tdo));
      check("sb_strb", 32'({tdoen, cap, shdr, upd, shir, trst}),
            32'(o.strb));
    end
  endtask

  task automatic load_ir(input logic [3:0] w);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, i == 3, w[i]);
    step(1, 1, 0);
    step(1, 0, 0);
  endtask

  initial begin
    // reset
    step(0, 1, 0);
    step(0, 0, 1);
    check("rst_tlr", 32'(trst), 32'd1);
    check("rst_ir", 32'(ir), 32'hf);
    check("rst_strb", 32'({tdoen, cap, shdr, upd, shir}), 32'd0);
    check("rst_tdo", 32'(tdo), 32'd1);
    step(1, 0, 0);

    // IR load of 0101 from RTI
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("ld_shir", 32'(shir), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("ld_tdo", 32'(tdo), 32'(i == 0));
      check("ld_hold", 32'(ir), 32'hf);
      step(1, i == 3, (i % 2) == 0);
    end
    step(1, 1, 0);
    check("ld_upd_hold", 32'(ir), 32'hf);
    step(1, 0, 0);
    check("ld_ir", 32'(ir), 32'h5);

    // paused IR shift of 1100
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("pa_hold", 32'(ir), 32'h5);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 1, 1);
    step(1, 1, 0);
    check("pa_upd_hold", 32'(ir), 32'h5);
    step(1, 0, 0);
    check("pa_ir", 32'(ir), 32'hc);

    // DR strobes from RTI
    step(1, 1, 0);
    step(1, 0, 0);
    check("dr_cap", 32'({cap, shdr, upd}), 32'b100);
    step(1, 0, 0);
    check("dr_sh1", 32'({cap, shdr, upd, tdoen}), 32'b0101);
    step(1, 0, 0);
    check("dr_sh2", 32'({cap, shdr, upd, tdoen}), 32'b0101);
    step(1, 1, 0);
    check("dr_ex1", 32'({cap, shdr, upd, tdoen}), 32'b0000);
    step(1, 1, 0);
    check("dr_upd", 32'({cap, shdr, upd}), 32'b001);
    check("dr_ir", 32'(ir), 32'hc);
    step(1, 0, 0);

    // forced TLR from SH_DR after loading 0000
    load_ir(4'b0000);
    check("f_ir0", 32'(ir), 32'h0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    check("f_tlr", 32'(trst), 32'd1);
    step(1, 1, 0);
    check("f_ir", 32'(ir), 32'hf);
    step(1, 0, 0);

    // reset in the middle of an IR shift
    load_ir(4'b0110);
    check("m_ir0", 32'(ir), 32'h6);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("m_tdo0", 32'(tdo), 32'd0);
    step(0, 0, 0);
    check("m_tlr", 32'(trst), 32'd1);
    check("m_ir", 32'(ir), 32'hf);
    check("m_tdo", 32'(tdo), 32'd1);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) != 0, 1'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
